// File: rtl/ama_riscv_pkg.sv
// Shared AMA-RISCV definitions used by the decoder and the immediate generator.
// Holds the immediate-format select encoding and its width.
package ama_riscv_pkg;

  localparam int unsigned IG_SEL_W = 4;

  localparam logic [IG_SEL_W-1:0] IG_I_TYPE = 4'd0;
  localparam logic [IG_SEL_W-1:0] IG_S_TYPE = 4'd1;
  localparam logic [IG_SEL_W-1:0] IG_B_TYPE = 4'd2;
  localparam logic [IG_SEL_W-1:0] IG_J_TYPE = 4'd3;
  localparam logic [IG_SEL_W-1:0] IG_U_TYPE = 4'd4;

endpackage

// File: rtl/ama_riscv_imm_decode.sv
// Combinational RISC-V immediate decode: instruction bits [31:7] plus format
// select in, 32-bit sign-extended immediate out. Unknown selects give zero.
module ama_riscv_imm_decode
  import ama_riscv_pkg::*;
(
  input  logic [IG_SEL_W-1:0] ig_sel,
  input  logic [31:7]         ig_in,
  output logic [31:0]         imm
);

  logic sign;

  assign sign = ig_in[31];

  // B and J immediates are halfword offsets, so bit 0 is always zero
  always_comb begin
    imm = 32'h0000_0000;
    case (ig_sel)
      IG_I_TYPE: imm = {{20{sign}}, ig_in[31:20]};
      IG_S_TYPE: imm = {{20{sign}}, ig_in[31:25], ig_in[11:7]};
      IG_B_TYPE: imm = {{19{sign}}, ig_in[31], ig_in[7], ig_in[30:25], ig_in[11:8], 1'b0};
      IG_J_TYPE: imm = {{11{sign}}, ig_in[31], ig_in[19:12], ig_in[20], ig_in[30:21], 1'b0};
      IG_U_TYPE: imm = {ig_in[31:12], 12'h000};
      default:   imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ama_riscv_imm_gen.sv
// Immediate generator with a stall hold register. Define IMM_GEN_OUT_REG_EN to
// register the output (1-cycle latency) instead of the live/held mux.
module ama_riscv_imm_gen
  import ama_riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [IG_SEL_W-1:0] ig_sel,
  input  logic [31:7]         ig_in,
  output logic [31:0]         ig_out
);

  logic [31:0] imm;
  logic [31:0] hold;

  ama_riscv_imm_decode u_decode (
    .ig_sel (ig_sel),
    .ig_in  (ig_in),
    .imm    (imm)
  );

  // Reset takes priority over a simultaneous enable
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= 32'h0000_0000;
    end else if (en) begin
      hold <= imm;
    end
  end

`ifdef IMM_GEN_OUT_REG_EN
  assign ig_out = hold;
`else
  assign ig_out = en ? imm : hold;
`endif

endmodule

// File: tb/tb_ama_riscv_imm_gen.sv
// Scoreboard bench for ama_riscv_imm_gen: directed format, invalid-select,
// hold and reset cases plus randomized decodes against an arithmetic model.
module tb_ama_riscv_imm_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  igSel;
  logic [31:7] igIn;
  logic [31:0] igOut;

  int checks;
  int errors;

  logic [31:0] expQ[$];
  string       nameQ[$];

  logic [31:0] modelHold;
  logic        lastRst;
  logic        lastEn;
  logic [31:0] lastLive;
  logic        stimDone;

  ama_riscv_imm_gen dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ig_sel (igSel),
    .ig_in  (igIn),
    .ig_out (igOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode built from field weights with plain integer arithmetic
  function automatic logic [31:0] refImm(input logic [3:0] sel, input logic [31:0] instr);
    longint v;
    longint s;
    s = instr[31] ? 1 : 0;
    v = 0;
    case (sel)
      4'd0: v = -s * 2048 + ((instr >> 20) & 32'h7FF);
      4'd1: v = -s * 2048 + (((instr >> 25) & 32'h3F) * 32) + ((instr >> 7) & 32'h1F);
      4'd2: v = -s * 4096 + (((instr >> 7) & 1) * 2048)
                + (((instr >> 25) & 32'h3F) * 32) + (((instr >> 8) & 32'hF) * 2);
      4'd3: v = -s * 1048576 + (((instr >> 12) & 32'hFF) * 4096)
                + (((instr >> 20) & 1) * 2048) + (((instr >> 21) & 32'h3FF) * 2);
      4'd4: v = longint'(instr & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("[TB] FAIL %s: ig_out=%08h expected=%08h", name, actual, want);
    end
  endtask

  // Drives one cycle of inputs just after an edge and queues the expected output
  task automatic applyStimulus(input logic rstV, input logic enV, input logic [3:0] sel,
                               input logic [31:0] instr, input logic [31:0] liveWant,
                               input string name);
    logic [31:0] want;
    @(posedge clk);
    if (lastRst) modelHold = 32'h0;
    else if (lastEn) modelHold = lastLive;
    #1;
    rst   = rstV;
    en    = enV;
    igSel = sel;
    igIn  = instr[31:7];
    lastRst  = rstV;
    lastEn   = enV;
    lastLive = liveWant;
`ifdef IMM_GEN_OUT_REG_EN
    want = modelHold;
`else
    want = enV ? liveWant : modelHold;
`endif
    expQ.push_back(want);
    nameQ.push_back(name);
  endtask

  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, igOut, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    logic [3:0]  sel;
    checks    = 0;
    errors    = 0;
    stimDone  = 1'b0;
    modelHold = 32'h0;
    lastRst   = 1'b1;
    lastEn    = 1'b0;
    lastLive  = 32'h0;
    rst   = 1'b1;
    en    = 1'b0;
    igSel = 4'd0;
    igIn  = '0;

    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, "reset_hold");
    applyStimulus(1'b0, 1'b0, 4'd0, 32'hFFF0_0000, 32'hFFFF_FFFF, "after_reset_held");
    applyStimulus(1'b1, 1'b1, 4'd0, 32'hFFF0_0000, 32'hFFFF_FFFF, "live_during_reset");
    applyStimulus(1'b0, 1'b0, 4'd4, 32'hABCD_E000, 32'hABCD_E000, "reset_beats_en");

    applyStimulus(1'b0, 1'b1, 4'd0, 32'hFFF0_0000, 32'hFFFF_FFFF, "i_neg");
    applyStimulus(1'b0, 1'b1, 4'd0, 32'h7FF0_0000, 32'h0000_07FF, "i_pos");
    applyStimulus(1'b0, 1'b1, 4'd1, 32'hFE00_0F80, 32'hFFFF_FFFF, "s_type");
    applyStimulus(1'b0, 1'b1, 4'd2, 32'hFE00_0F80, 32'hFFFF_FFFE, "b_type");
    applyStimulus(1'b0, 1'b1, 4'd3, 32'hFFFF_F000, 32'hFFFF_FFFE, "j_type");
    applyStimulus(1'b0, 1'b1, 4'd4, 32'hFFFF_F000, 32'hFFFF_F000, "u_type");
    applyStimulus(1'b0, 1'b1, 4'd5, $urandom, 32'h0, "invalid_sel5");
    applyStimulus(1'b0, 1'b1, 4'd15, $urandom, 32'h0, "invalid_sel15");

    applyStimulus(1'b0, 1'b1, 4'd4, 32'h1234_5000, 32'h1234_5000, "hold_capture");
    applyStimulus(1'b0, 1'b0, 4'd0, 32'hFFF0_0000, 32'hFFFF_FFFF, "hold_keep1");
    applyStimulus(1'b0, 1'b0, 4'd2, 32'hFE00_0F80, 32'hFFFF_FFFE, "hold_keep2");
    applyStimulus(1'b1, 1'b0, 4'd3, 32'hFFFF_F000, 32'hFFFF_FFFE, "hold_rst_pulse");
    applyStimulus(1'b0, 1'b0, 4'd4, 32'h1234_5000, 32'h1234_5000, "hold_cleared");

    for (int i = 0; i < 64; i++) begin
      instr = $urandom;
      sel   = 4'($urandom_range(4, 0));
      applyStimulus(1'b0, 1'b1, sel, instr, refImm(sel, instr), $sformatf("random_%0d", i));
    end

    applyStimulus(1'b0, 1'b0, 4'd0, $urandom, 32'h0, "random_tail_hold");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
    end
    stimDone = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
